// File: rtl/hex_font_pkg.sv
// Shared font data and renderer state type for the hex glyph renderer.
// Each glyph is 5 rows of 3 columns. Row r sits in bits [14-3r -: 3] and
// column c of that row is bit 12-3r+c, so in the octal literals below each
// digit is one row (top first) with col0 = weight 1, col1 = 2, col2 = 4.
package hex_font_pkg;

    localparam int GLYPH_W = 3;
    localparam int GLYPH_H = 5;
    localparam int CELL_W  = 7;

    localparam logic [14:0] GLYPH_0 = 15'o75557;
    localparam logic [14:0] GLYPH_1 = 15'o44444;
    localparam logic [14:0] GLYPH_2 = 15'o74717;
    localparam logic [14:0] GLYPH_3 = 15'o74747;
    localparam logic [14:0] GLYPH_4 = 15'o55744;
    localparam logic [14:0] GLYPH_5 = 15'o71747;
    localparam logic [14:0] GLYPH_6 = 15'o71757;
    localparam logic [14:0] GLYPH_7 = 15'o74444;
    localparam logic [14:0] GLYPH_8 = 15'o75757;
    localparam logic [14:0] GLYPH_9 = 15'o75747;
    localparam logic [14:0] GLYPH_A = 15'o75755;
    localparam logic [14:0] GLYPH_B = 15'o35353;
    localparam logic [14:0] GLYPH_C = 15'o71117;
    localparam logic [14:0] GLYPH_D = 15'o35553;
    localparam logic [14:0] GLYPH_E = 15'o71717;
    localparam logic [14:0] GLYPH_F = 15'o71711;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [14:0] glyph_of(input logic [3:0] nibble);
        logic [14:0] g;
        case (nibble)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

    // Pixel of a glyph at (row, col); col 0 is the leftmost column.
    function automatic logic glyph_bit(input logic [14:0] glyph,
                                       input logic [2:0]  row,
                                       input logic [1:0]  col);
        logic [2:0] bits;
        logic       b;
        case (row)
            3'd0:    bits = glyph[14:12];
            3'd1:    bits = glyph[11:9];
            3'd2:    bits = glyph[8:6];
            3'd3:    bits = glyph[5:3];
            default: bits = glyph[2:0];
        endcase
        case (col)
            2'd0:    b = bits[0];
            2'd1:    b = bits[1];
            default: b = bits[2];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// Registered nibble-to-glyph lookup for the hex font.
module hex_glyph_rom
    import hex_font_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  nibble,
    output logic [14:0] glyph
);

    // Register the font entry of the presented nibble every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            glyph <= 15'd0;
        end else begin
            glyph <= glyph_of(nibble);
        end
    end

endmodule

// File: rtl/hex_byte_renderer.sv
// Two-requester round-robin draw scheduler: turns each accepted byte into
// 35 framebuffer pixel writes (two 3x5 glyphs plus a cleared separator).
module hex_byte_renderer
    import hex_font_pkg::*;
#(
    parameter int X_BITS = 6,
    parameter int Y_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [2*X_BITS-1:0]      req_x,
    input  logic [2*Y_BITS-1:0]      req_y,
    input  logic [15:0]              req_byte,
    output logic                     fb_we,
    output logic [X_BITS+Y_BITS-1:0] fb_addr,
    output logic                     fb_data,
    input  logic                     fb_stall,
    output logic                     busy,
    output logic                     done,
    output logic                     grant_id
);

    localparam logic [2:0] LAST_ROW = 3'(GLYPH_H - 1);
    localparam logic [2:0] LAST_COL = 3'(CELL_W - 1);
    localparam logic [2:0] SEP_COL  = 3'(GLYPH_W);
    localparam logic [2:0] LO_COL0  = 3'(GLYPH_W + 1);

    state_t                     state_r, state_s;
    logic                       ptr_r;
    logic                       id_r;
    logic [X_BITS-1:0]          x_r, x_s;
    logic [Y_BITS-1:0]          y_r, y_s;
    logic [7:0]                 byte_r, byte_s;
    logic [2:0]                 row_r, row_s;
    logic [2:0]                 col_r, col_s;
    logic                       gnt_valid_s;
    logic                       gnt_id_s;
    logic [1:0]                 req_ready_s;
    logic                       xfer_s;
    logic [14:0]                glyph_hi_s, glyph_lo_s;
    logic [1:0]                 lo_col_s;
    logic [X_BITS-1:0]          x_sum_s;
    logic [Y_BITS-1:0]          y_sum_s;
    logic [X_BITS+Y_BITS-1:0]   px_addr_s;
    logic                       px_data_s;
    logic                       fb_we_r;
    logic [X_BITS+Y_BITS-1:0]   fb_addr_r;
    logic                       fb_data_r;
    logic                       done_r;

    // Round-robin grant, ready strobe and the request fields of the winner.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = ptr_r;
        case (req_valid)
            2'b01: begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b0;
            end
            2'b10: begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b1;
            end
            2'b11: begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = ptr_r;
            end
            default: begin
                gnt_valid_s = 1'b0;
                gnt_id_s    = ptr_r;
            end
        endcase
        if ((state_r == IDLE) && !rst && gnt_valid_s) begin
            req_ready_s = gnt_id_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
        xfer_s = |(req_valid & req_ready_s);
        if (xfer_s) begin
            x_s    = gnt_id_s ? req_x[2*X_BITS-1:X_BITS] : req_x[X_BITS-1:0];
            y_s    = gnt_id_s ? req_y[2*Y_BITS-1:Y_BITS] : req_y[Y_BITS-1:0];
            byte_s = gnt_id_s ? req_byte[15:8] : req_byte[7:0];
        end else begin
            x_s    = x_r;
            y_s    = y_r;
            byte_s = byte_r;
        end
    end

    // The ROMs see the next byte value so the glyphs are ready in LOAD.
    hex_glyph_rom u_rom_hi (
        .clk    (clk),
        .rst    (rst),
        .nibble (byte_s[7:4]),
        .glyph  (glyph_hi_s)
    );

    hex_glyph_rom u_rom_lo (
        .clk    (clk),
        .rst    (rst),
        .nibble (byte_s[3:0]),
        .glyph  (glyph_lo_s)
    );

    // Next state and next pixel position; counters hold while stalled.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        col_s   = col_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = DRAW;
                row_s   = 3'd0;
                col_s   = 3'd0;
            end
            DRAW: begin
                if (fb_stall) begin
                    state_s = DRAW;
                end else if ((row_r == LAST_ROW) && (col_r == LAST_COL)) begin
                    state_s = DONE;
                end else if (col_r == LAST_COL) begin
                    row_s = row_r + 3'd1;
                    col_s = 3'd0;
                end else begin
                    col_s = col_r + 3'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Address and colour of the pixel at the next position; coordinates wrap.
    always_comb begin
        lo_col_s  = 2'(col_s - LO_COL0);
        y_sum_s   = y_r + Y_BITS'(row_s);
        x_sum_s   = x_r + X_BITS'(col_s);
        px_addr_s = {y_sum_s, x_sum_s};
        if (col_s < SEP_COL) begin
            px_data_s = glyph_bit(glyph_hi_s, row_s, col_s[1:0]);
        end else if (col_s == SEP_COL) begin
            px_data_s = 1'b0;
        end else begin
            px_data_s = glyph_bit(glyph_lo_s, row_s, lo_col_s);
        end
    end

    // State, counters, accepted request fields and arbitration pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            row_r   <= 3'd0;
            col_r   <= 3'd0;
            x_r     <= '0;
            y_r     <= '0;
            byte_r  <= 8'd0;
            id_r    <= 1'b0;
            ptr_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            col_r   <= col_s;
            x_r     <= x_s;
            y_r     <= y_s;
            byte_r  <= byte_s;
            if (xfer_s) begin
                id_r  <= gnt_id_s;
                ptr_r <= ~gnt_id_s;
            end else begin
                id_r  <= id_r;
                ptr_r <= ptr_r;
            end
        end
    end

    // Registered framebuffer port and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we_r   <= 1'b0;
            fb_addr_r <= '0;
            fb_data_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == DRAW) && (state_s == DONE);
            if (state_s == DRAW) begin
                if ((state_r == LOAD) || !fb_stall) begin
                    fb_we_r   <= 1'b1;
                    fb_addr_r <= px_addr_s;
                    fb_data_r <= px_data_s;
                end else begin
                    fb_we_r   <= fb_we_r;
                    fb_addr_r <= fb_addr_r;
                    fb_data_r <= fb_data_r;
                end
            end else begin
                fb_we_r <= 1'b0;
            end
        end
    end

    assign req_ready = req_ready_s;
    assign fb_we     = fb_we_r;
    assign fb_addr   = fb_addr_r;
    assign fb_data   = fb_data_r;
    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign grant_id  = id_r;

endmodule

// File: tb/tb_hex_byte_renderer.sv
// Self-checking bench for hex_byte_renderer: a queue-based pixel model built
// from drawn font art, checked every cycle, plus hand-computed expectations.
module tb_hex_byte_renderer;

    localparam int XB = 6;
    localparam int YB = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [2*XB-1:0]   req_x = '0;
    logic [2*YB-1:0]   req_y = '0;
    logic [15:0]       req_byte = 16'd0;
    logic              fb_we;
    logic [XB+YB-1:0]  fb_addr;
    logic              fb_data;
    logic              fb_stall = 1'b0;
    logic              busy;
    logic              done;
    logic              grant_id;

    hex_byte_renderer #(.X_BITS(XB), .Y_BITS(YB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_byte  (req_byte),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_stall  (fb_stall),
        .busy      (busy),
        .done      (done),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Font drawn as rows of three characters, top row first, left to right.
    string art [16] = '{
        "####.##.##.####", "..#..#..#..#..#", "###..#####..###", "###..####..####",
        "#.##.####..#..#", "####..###..####", "####..####.####", "###..#..#..#..#",
        "####.#####.####", "####.####..####", "####.#####.##.#", "##.#.###.#.###.",
        "####..#..#..###", "##.#.##.##.###.", "####..####..###", "####..####..#.."
    };

    typedef struct { int x; int y; int b; } job_t;
    typedef struct { int addr; int data; } px_t;
    typedef struct { int c; int a; int d; } wr_t;
    typedef struct { int c; int id; } xf_t;

    job_t jq0[$];
    job_t jq1[$];
    px_t  px_q[$];
    wr_t  wlog[$];
    xf_t  xlog[$];
    int   dlog[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_on = 1'b0;
    logic [1:0] hs = 2'b00;
    int   stall_at = -100;
    int   stall_len = 0;

    bit   m_load = 1'b0;
    bit   m_done = 1'b0;
    int   m_ptr = 0;
    int   m_gid = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expand one byte into its 35 expected pixels, row-major.
    function automatic void fill(int x, int y, int b);
        int    hi = b / 16;
        int    lo = b % 16;
        string s;
        px_t   p;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (c < 3) begin
                    s = art[hi];
                    p.data = (s[r*3+c] == "#") ? 1 : 0;
                end else if (c == 3) begin
                    p.data = 0;
                end else begin
                    s = art[lo];
                    p.data = (s[r*3+c-4] == "#") ? 1 : 0;
                end
                p.addr = ((y + r) % 32) * 64 + ((x + c) % 64);
                px_q.push_back(p);
            end
        end
    endfunction

    // Model and compare process, evaluated mid-cycle.
    initial begin
        logic [1:0] exp_ready;
        bit         exp_busy;
        bit         exp_we;
        int         g;
        wr_t        w;
        xf_t        xf;
        job_t       j;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if (chk_on) begin
                exp_busy = m_load || m_done || (px_q.size() > 0);
                exp_we   = !m_load && !m_done && (px_q.size() > 0);
                g = -1;
                if (!exp_busy && !rst) begin
                    case (req_valid)
                        2'b01:   g = 0;
                        2'b10:   g = 1;
                        2'b11:   g = m_ptr;
                        default: g = -1;
                    endcase
                end
                exp_ready = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
                chk("busy", busy, exp_busy);
                chk("done", done, m_done);
                chk("req_ready", req_ready, exp_ready);
                chk("grant_id", grant_id, m_gid);
                chk("fb_we", fb_we, exp_we);
                if (exp_we) begin
                    chk("fb_addr", fb_addr, px_q[0].addr);
                    chk("fb_data", fb_data, px_q[0].data);
                end
                if (fb_we && !fb_stall) begin
                    w.c = cyc; w.a = int'(fb_addr); w.d = int'(fb_data);
                    wlog.push_back(w);
                end
                if (done) dlog.push_back(cyc);
                if (rst) begin
                    px_q.delete();
                    m_load = 1'b0;
                    m_done = 1'b0;
                    m_ptr  = 0;
                    m_gid  = 0;
                end else if (m_done) begin
                    m_done = 1'b0;
                end else if (m_load) begin
                    m_load = 1'b0;
                end else if (px_q.size() > 0) begin
                    if (!fb_stall) begin
                        void'(px_q.pop_front());
                        if (px_q.size() == 0) m_done = 1'b1;
                    end
                end else if (g >= 0) begin
                    j = (g == 0) ? jq0[0] : jq1[0];
                    fill(j.x, j.y, j.b);
                    m_load = 1'b1;
                    m_gid  = g;
                    m_ptr  = 1 - g;
                    xf.c = cyc; xf.id = g;
                    xlog.push_back(xf);
                end
            end
        end
    end

    // Requester and stall driver, just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hs[0] && jq0.size() > 0) void'(jq0.pop_front());
            if (hs[1] && jq1.size() > 0) void'(jq1.pop_front());
            if (jq0.size() > 0) begin
                req_valid[0]     = 1'b1;
                req_x[XB-1:0]    = XB'(jq0[0].x);
                req_y[YB-1:0]    = YB'(jq0[0].y);
                req_byte[7:0]    = 8'(jq0[0].b);
            end else begin
                req_valid[0] = 1'b0;
            end
            if (jq1.size() > 0) begin
                req_valid[1]       = 1'b1;
                req_x[2*XB-1:XB]   = XB'(jq1[0].x);
                req_y[2*YB-1:YB]   = YB'(jq1[0].y);
                req_byte[15:8]     = 8'(jq1[0].b);
            end else begin
                req_valid[1] = 1'b0;
            end
            fb_stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_job(input int r, input int x, input int y, input int b);
        job_t j;
        j.x = x; j.y = y; j.b = b;
        if (r == 0) jq0.push_back(j);
        else jq1.push_back(j);
    endtask

    task automatic clear_logs();
        wlog.delete();
        xlog.delete();
        dlog.delete();
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (dlog.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        chk("done_count", dlog.size(), n);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        int T;
        int rc;
        int k;
        bit row0 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk_on = 1'b1;

        // Single byte 0x1A at (0,0) from requester 0.
        clear_logs();
        push_job(0, 0, 0, 8'h1A);
        wait_done(1, 200);
        chk("t1_xfers", xlog.size(), 1);
        chk("t1_writes", wlog.size(), 35);
        if (xlog.size() == 1 && wlog.size() == 35 && dlog.size() == 1) begin
            T = xlog[0].c;
            chk("t1_id", xlog[0].id, 0);
            chk("t1_first_we", wlog[0].c, T + 2);
            chk("t1_last_we", wlog[34].c, T + 36);
            chk("t1_done_cyc", dlog[0], T + 37);
            for (int c = 0; c < 7; c++) begin
                chk("t1_row0_addr", wlog[c].a, c);
                chk("t1_row0_data", wlog[c].d, row0[c]);
            end
        end

        // Wrap: requester 1 draws 0xFF at (62,30).
        clear_logs();
        push_job(1, 62, 30, 8'hFF);
        wait_done(1, 200);
        chk("wrap_writes", wlog.size(), 35);
        if (wlog.size() == 35 && xlog.size() == 1) begin
            chk("wrap_id", xlog[0].id, 1);
            chk("wrap_col2_addr", wlog[2].a, 30 * 64 + 0);
            chk("wrap_col2_data", wlog[2].d, 1);
            chk("wrap_row2_addr", wlog[14].a, 0 * 64 + 62);
            chk("wrap_row2_data", wlog[14].d, 1);
            chk("wrap_last_addr", wlog[34].a, 2 * 64 + 4);
            chk("wrap_last_data", wlog[34].d, 0);
        end

        // Contention: both requesters keep three bytes each queued.
        clear_logs();
        push_job(0, 8, 4, 8'h23);
        push_job(0, 20, 10, 8'h45);
        push_job(0, 2, 2, 8'hCD);
        push_job(1, 30, 12, 8'h67);
        push_job(1, 40, 20, 8'h9B);
        push_job(1, 50, 1, 8'hE0);
        wait_done(6, 600);
        chk("cont_xfers", xlog.size(), 6);
        if (xlog.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("cont_order", xlog[i].id, i % 2);
                if (i > 0) chk("cont_spacing", xlog[i].c - xlog[i-1].c, 38);
            end
        end

        // Stall three cycles on row 2, col 4 of 0x88 drawn at (10,3).
        clear_logs();
        push_job(0, 10, 3, 8'h88);
        k = 0;
        while (xlog.size() == 0 && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("stall_xfer", xlog.size(), 1);
        if (xlog.size() == 1) begin
            T = xlog[0].c;
            stall_at = T + 20;
            stall_len = 3;
            while (cyc < T + 20) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk("stall_hold_we", fb_we, 1);
                chk("stall_hold_addr", fb_addr, 5 * 64 + 14);
                chk("stall_hold_data", fb_data, 1);
                @(negedge clk);
            end
            wait_done(1, 200);
            chk("stall_writes", wlog.size(), 35);
            if (dlog.size() == 1) chk("stall_done_cyc", dlog[0], T + 40);
        end
        stall_len = 0;

        // Reset in the middle of a draw from requester 1.
        clear_logs();
        push_job(1, 5, 5, 8'h5C);
        k = 0;
        while (wlog.size() < 10 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("rstmid_progress", wlog.size(), 10);
        rst = 1'b1;
        rc = cyc;
        push_job(0, 0, 0, 8'h3E);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_fb_we", fb_we, 0);
        chk("rstmid_fb_addr", fb_addr, 0);
        chk("rstmid_fb_data", fb_data, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_grant_id", grant_id, 0);
        wait_done(1, 200);
        chk("rstmid_xfers", xlog.size(), 2);
        if (xlog.size() == 2) begin
            chk("rstmid_new_cyc", xlog[1].c, rc + 1);
            chk("rstmid_new_id", xlog[1].id, 0);
            if (dlog.size() == 1) chk("rstmid_done_cyc", dlog[0], xlog[1].c + 37);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
